// File: rtl/tiny_pkg.sv
// Shared defaults, register map and working-state record for the tinyenc cipher block.
package tiny_pkg;
  localparam logic [63:0] KEY_DEF   = 64'h816fc52b09e74da3;
  localparam logic [15:0] DELTA_DEF = 16'h1;
  localparam int          SHL_DEF   = 4;
  localparam int          SHR_DEF   = 5;
  localparam logic [7:0]  ROUND_DEF = 8'd1;

  localparam logic [31:0] ADDR_K10   = 32'h0;
  localparam logic [31:0] ADDR_K32   = 32'h4;
  localparam logic [31:0] ADDR_DELTA = 32'h8;
  localparam logic [31:0] ADDR_STAT  = 32'hC;

  // Per-block snapshot: config can change underneath without disturbing a block in flight.
  typedef struct packed {
    logic [63:0] key;
    logic [15:0] delta;
    logic [15:0] sum;
    logic [15:0] y;
    logic [15:0] x;
  } work_t;
endpackage

// File: rtl/tiny_mix.sv
// Round mix function: ((v<<SHL)+ka) ^ (v+sum) ^ ((v>>SHR)+kb), all modulo 2^16.
module tiny_mix #(
  parameter int SHL = 4,
  parameter int SHR = 5
) (
  input  logic [15:0] v,
  input  logic [15:0] sum,
  input  logic [15:0] ka,
  input  logic [15:0] kb,
  output logic [15:0] f
);
  logic [15:0] shl_v, shr_v;
  assign shl_v = v << SHL;
  assign shr_v = v >> SHR;
  assign f     = (shl_v + ka) ^ (v + sum) ^ (shr_v + kb);
endmodule

// File: rtl/tinyenc.sv
// Iterative 32-bit block encryptor, one round per clock, with a small register config port.
module tinyenc import tiny_pkg::*; #(
  parameter logic [63:0] KEY   = KEY_DEF,
  parameter logic [15:0] DELTA = DELTA_DEF,
  parameter int          SHL   = SHL_DEF,
  parameter int          SHR   = SHR_DEF,
  parameter logic [7:0]  ROUND = ROUND_DEF
) (
  input  logic        clk,
  input  logic        prstb,
  input  logic        req,
  input  logic [31:0] wdata,
  output logic        ack,
  output logic [31:0] rdata,
  input  logic        psel,
  input  logic        penable,
  input  logic        pwrite,
  input  logic [31:0] paddr,
  input  logic [31:0] pwdata,
  output logic [31:0] prdata,
  output logic        pready
);
  if (ROUND == 8'd0) begin : g_bad_round
    $error("tinyenc: ROUND must be nonzero");
  end

  logic [63:0] key_q;
  logic [15:0] delta_q;
  work_t       w_q;
  logic [7:0]  i_q;
  logic [31:0] rdata_q, prdata_q;
  logic [15:0] sum_d, x_d, y_d, fx, fy;
  logic        busy;

  assign busy   = (i_q != 8'd0);
  assign ack    = ~busy;
  assign rdata  = rdata_q;
  assign prdata = prdata_q;
  assign pready = 1'b1;

  // x update uses the old y; y update uses the freshly computed x.
  assign sum_d = w_q.sum + w_q.delta;
  tiny_mix #(.SHL(SHL), .SHR(SHR)) u_mix_x (
    .v(w_q.y), .sum(sum_d), .ka(w_q.key[15:0]), .kb(w_q.key[31:16]), .f(fx)
  );
  assign x_d = w_q.x + fx;
  tiny_mix #(.SHL(SHL), .SHR(SHR)) u_mix_y (
    .v(x_d), .sum(sum_d), .ka(w_q.key[47:32]), .kb(w_q.key[63:48]), .f(fy)
  );
  assign y_d = w_q.y + fy;

  always_ff @(posedge clk or negedge prstb) begin
    if (!prstb) begin
      w_q     <= '0;
      i_q     <= 8'd0;
      rdata_q <= '0;
    end else if (ack && req) begin
      w_q <= '{key: key_q, delta: delta_q, sum: 16'h0, y: wdata[31:16], x: wdata[15:0]};
      i_q <= ROUND;
    end else if (busy) begin
      w_q.sum <= sum_d;
      w_q.x   <= x_d;
      w_q.y   <= y_d;
      i_q     <= i_q - 8'd1;
      if (i_q == 8'd1) rdata_q <= {y_d, x_d};
    end
  end

  always_ff @(posedge clk or negedge prstb) begin
    if (!prstb) begin
      key_q    <= KEY;
      delta_q  <= DELTA;
      prdata_q <= '0;
    end else begin
      if (psel && penable && pwrite) begin
        case (paddr)
          ADDR_K10:   key_q[31:0]  <= pwdata;
          ADDR_K32:   key_q[63:32] <= pwdata;
          ADDR_DELTA: delta_q      <= pwdata[15:0];
          default: ;
        endcase
      end
      if (psel) begin
        case (paddr)
          ADDR_K10:   prdata_q <= key_q[31:0];
          ADDR_K32:   prdata_q <= key_q[63:32];
          ADDR_DELTA: prdata_q <= {16'h0, delta_q};
          ADDR_STAT:  prdata_q <= {16'h0, i_q, 7'h0, busy};
          default:    prdata_q <= '0;
        endcase
      end
    end
  end
endmodule
